// File: rtl/cmu_assoc.sv
// cmu_assoc -- 2-way set-associative, write-back, write-allocate cache
// management unit between a CPU load/store port and a word-wide memory bus.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   addr_rw       : CPU byte address (word aligned)
//   en_r, en_w    : CPU read / write request (en_w wins when both are set)
//   data_w        : CPU write data
//   data_r        : CPU read data, registered, updated only by a completed read
//   stall         : CPU must hold addr_rw/en_*/data_w while this is high
//   mem_cs_o      : memory chip select
//   mem_we_o      : memory write enable
//   mem_addr_o    : memory byte address of the word being transferred
//   mem_data_o    : memory write data
//   mem_data_i    : memory read data
//   mem_ack_i     : one-cycle pulse per transferred word
//   hit_cnt       : completed hit accesses (wrapping)
//   miss_cnt      : misses (wrapping)
//
// CPU handshake: a request (en_r|en_w) completes on the rising edge where
// stall is low; stall is low only when the FSM is IDLE and the lookup hits.
// A miss refills the line (after writing back a dirty victim) and the held
// request then completes as a hit.
// Memory handshake: mem_cs_o/mem_we_o/mem_addr_o/mem_data_o stay constant
// until the edge that samples mem_ack_i high; that edge moves on to the next
// word. The FSM state is available on the internal signal `state`.

module cmu_assoc #(
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int SET_WIDTH        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_rw,
    input  logic        en_r,
    input  logic        en_w,
    input  logic [31:0] data_w,
    output logic [31:0] data_r,
    output logic        stall,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    // Derived from the other two so the address always splits into 32 bits.
    localparam int TAG_BITS = 32 - SET_WIDTH - LINE_WORDS_WIDTH - 2;
    localparam int SETS     = 1 << SET_WIDTH;
    localparam int LINE     = 1 << LINE_WORDS_WIDTH;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_BACK      = 3'd1;
    localparam logic [2:0] S_BACK_WAIT = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_FILL_WAIT = 3'd4;

    // Storage
    logic [TAG_BITS-1:0] tag_q   [SETS][2];
    logic [31:0]         data_q  [SETS][2][LINE];
    logic [1:0]          valid_q [SETS];
    logic [1:0]          dirty_q [SETS];
    logic [SETS-1:0]     lru_q;       // way to evict next in each set

    logic [2:0]                  state;
    logic [2:0]                  next_state;
    logic [LINE_WORDS_WIDTH-1:0] word_count;
    logic [LINE_WORDS_WIDTH-1:0] next_wc;
    logic                        victim_q;

    // Address split
    logic [LINE_WORDS_WIDTH-1:0] a_word;
    logic [SET_WIDTH-1:0]        a_set;
    logic [TAG_BITS-1:0]         a_tag;
    logic                        unused_addr_bits;

    assign a_word           = addr_rw[LINE_WORDS_WIDTH+1:2];
    assign a_set            = addr_rw[SET_WIDTH+LINE_WORDS_WIDTH+1:LINE_WORDS_WIDTH+2];
    assign a_tag            = addr_rw[31:32-TAG_BITS];
    assign unused_addr_bits = ^addr_rw[1:0];

    // Lookup
    logic hit0, hit1, hit, hit_way, req, hit_acc, last_word;
    logic victim_sel, victim_cur;

    assign hit0      = valid_q[a_set][0] && (tag_q[a_set][0] == a_tag);
    assign hit1      = valid_q[a_set][1] && (tag_q[a_set][1] == a_tag);
    assign hit       = hit0 | hit1;
    assign hit_way   = hit1;
    assign req       = en_r | en_w;
    assign stall     = req & !((state == S_IDLE) & hit);
    assign hit_acc   = req & (state == S_IDLE) & hit;
    assign last_word = &word_count;

    // Prefer an empty way; otherwise evict the least recently used one.
    assign victim_sel = !valid_q[a_set][0] ? 1'b0 :
                        !valid_q[a_set][1] ? 1'b1 : lru_q[a_set];
    // In IDLE the victim is not latched yet, but the memory outputs for the
    // first BACK word are computed on the same edge that latches it.
    assign victim_cur = (state == S_IDLE) ? victim_sel : victim_q;

    // Next-state logic
    always_comb begin
        next_state = state;
        next_wc    = word_count;
        case (state)
            S_IDLE: begin
                if (req && !hit) begin
                    next_wc    = '0;
                    next_state = (valid_q[a_set][victim_sel] && dirty_q[a_set][victim_sel])
                                 ? S_BACK : S_FILL;
                end
            end
            S_BACK: begin
                if (mem_ack_i) begin
                    next_wc = word_count + LINE_WORDS_WIDTH'(1);
                    if (last_word) next_state = S_BACK_WAIT;
                end
            end
            S_BACK_WAIT: begin
                next_wc    = '0;
                next_state = S_FILL;
            end
            S_FILL: begin
                if (mem_ack_i) begin
                    next_wc = word_count + LINE_WORDS_WIDTH'(1);
                    if (last_word) next_state = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Memory outputs are registered from the next state / next word so they
    // stay constant for the whole transfer of a word.
    logic        mem_cs_n;
    logic        mem_we_n;
    logic [31:0] mem_addr_n;

    always_comb begin
        mem_cs_n   = (next_state == S_BACK) || (next_state == S_FILL);
        mem_we_n   = (next_state == S_BACK);
        mem_addr_n = '0;
        case (next_state)
            S_BACK:  mem_addr_n = {tag_q[a_set][victim_cur], a_set, next_wc, 2'b00};
            S_FILL:  mem_addr_n = {a_tag, a_set, next_wc, 2'b00};
            default: mem_addr_n = '0;
        endcase
    end

    // Control state, metadata and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_count <= '0;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 2'b00;
                dirty_q[s] <= 2'b00;
            end
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            data_r     <= '0;
            mem_cs_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            state      <= next_state;
            word_count <= next_wc;

            if ((state == S_IDLE) && req && !hit) begin
                victim_q <= victim_sel;
                miss_cnt <= miss_cnt + 32'd1;
            end

            if (hit_acc) begin
                lru_q[a_set] <= ~hit_way;
                hit_cnt      <= hit_cnt + 32'd1;
                if (en_w) dirty_q[a_set][hit_way] <= 1'b1;
                else      data_r <= data_q[a_set][hit_way][a_word];
            end

            // The line becomes valid only once its last word has arrived.
            if ((state == S_FILL) && mem_ack_i && last_word) begin
                valid_q[a_set][victim_q] <= 1'b1;
                dirty_q[a_set][victim_q] <= 1'b0;
            end

            mem_cs_o   <= mem_cs_n;
            mem_we_o   <= mem_we_n;
            mem_addr_o <= mem_addr_n;
            if (next_state == S_BACK) mem_data_o <= data_q[a_set][victim_cur][next_wc];
        end
    end

    // Tag and data arrays need no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if ((state == S_FILL) && mem_ack_i) begin
            data_q[a_set][victim_q][word_count] <= mem_data_i;
            if (last_word) tag_q[a_set][victim_q] <= a_tag;
        end
        if (hit_acc && en_w) data_q[a_set][hit_way][a_word] <= data_w;
    end

endmodule

// File: tb/tb_cmu_assoc.sv
// Directed bench for cmu_assoc: a CPU driver, a memory responder with a
// configurable ack delay, and two expected queues (CPU read data and memory
// transfers) checked by independent monitor processes.

module tb_cmu_assoc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_rw;
    logic        en_r;
    logic        en_w;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    cmu_assoc dut (
        .clk        (clk),
        .rst        (rst),
        .addr_rw    (addr_rw),
        .en_r       (en_r),
        .en_w       (en_w),
        .data_w     (data_w),
        .data_r     (data_r),
        .stall      (stall),
        .mem_cs_o   (mem_cs_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;

    logic [31:0] exp_rd_q[$];    // expected data_r after each completed read
    logic [64:0] exp_mem_q[$];   // {we, addr, wdata} per memory word transfer
    logic [31:0] mem_store [logic [31:0]];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Untouched memory returns 0xA0 + word index + (tag << 8).
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return 32'hA0 + {30'b0, a[3:2]} + (a & 32'hFFFF_FF00);
    endfunction

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
    endtask

    task automatic push_back_word(input logic [31:0] a, input logic [31:0] d);
        exp_mem_q.push_back({1'b1, a, d});
    endtask

    // Memory responder: acks after ack_delay idle cycles, checks each transfer.
    initial begin
        int          wait_cnt;
        logic [31:0] held;
        logic [64:0] e;
        wait_cnt  = 0;
        held      = 0;
        mem_ack_i = 1'b0;
        mem_data_i = 32'h0;
        forever begin
            @(negedge clk);
            if (rst || !mem_cs_o) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (wait_cnt < ack_delay) begin
                if (wait_cnt > 0) check("mem_addr_stable", mem_addr_o, held);
                held      = mem_addr_o;
                wait_cnt++;
                mem_ack_i = 1'b0;
            end else begin
                if (ack_delay > 0) check("mem_addr_stable", mem_addr_o, held);
                wait_cnt = 0;
                if (exp_mem_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mem_unexpected: got we=%b addr %h, expected no transfer",
                             mem_we_o, mem_addr_o);
                end else begin
                    e = exp_mem_q.pop_front();
                    check("mem_we", {31'b0, mem_we_o}, {31'b0, e[64]});
                    check("mem_addr", mem_addr_o, e[63:32]);
                    if (e[64]) check("mem_wdata", mem_data_o, e[31:0]);
                end
                if (mem_we_o) mem_store[mem_addr_o] = mem_data_o;
                else mem_data_i = mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o]
                                                               : mem_default(mem_addr_o);
                mem_ack_i = 1'b1;
            end
        end
    end

    // CPU read monitor: a read completing at a posedge is checked one cycle later.
    initial begin
        logic        rd_pend;
        logic [31:0] e;
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (exp_rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_unexpected: got data_r %h, expected no read", data_r);
                end else begin
                    e = exp_rd_q.pop_front();
                    check("data_r", data_r, e);
                end
            end
            rd_pend = !rst && en_r && !en_w && !stall;
        end
    end

    // CPU driver: holds the request until stall drops, checks stalled cycles.
    task automatic cpu_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input int exp_stall, input string nm);
        int n;
        if (!we) exp_rd_q.push_back(exp_rd);
        addr_rw = a;
        data_w  = wd;
        en_w    = we;
        en_r    = !we;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (stall) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got stall after %0d cycles, expected release", nm, n);
        end
        check({nm, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        @(posedge clk);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    task automatic check_counts(input string nm, input logic [31:0] h, input logic [31:0] m);
        check({nm, "_hit_cnt"}, hit_cnt, h);
        check({nm, "_miss_cnt"}, miss_cnt, m);
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_mem_cs"}, {31'b0, mem_cs_o}, 32'h0);
        check({nm, "_mem_we"}, {31'b0, mem_we_o}, 32'h0);
        check({nm, "_mem_addr"}, mem_addr_o, 32'h0);
        check({nm, "_mem_data"}, mem_data_o, 32'h0);
        check({nm, "_data_r"}, data_r, 32'h0);
        check_counts(nm, 32'h0, 32'h0);
    endtask

    // Main stimulus
    initial begin
        int n;
        rst = 1'b1;
        en_r = 1'b0;
        en_w = 1'b0;
        addr_rw = 32'h0;
        data_w = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        check("reset_stall", {31'b0, stall}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean miss into set 1 way0, then hit write / hit read.
        push_fill(32'h10);
        cpu_access(1'b0, 32'h10, 32'h0, 32'hA0, 6, "rd_10");
        check_counts("after_rd_10", 32'd1, 32'd1);
        cpu_access(1'b1, 32'h14, 32'hDEAD, 32'h0, 0, "wr_14");
        cpu_access(1'b0, 32'h14, 32'h0, 32'hDEAD, 0, "rd_14");
        check_counts("after_rd_14", 32'd3, 32'd1);

        // Second way of set 1, then back-to-back hits; 0x10 last so LRU -> way1.
        push_fill(32'h110);
        cpu_access(1'b0, 32'h110, 32'h0, 32'h1A0, 6, "rd_110");
        cpu_access(1'b0, 32'h11C, 32'h0, 32'h1A3, 0, "rd_11c");
        cpu_access(1'b0, 32'h10, 32'h0, 32'hA0, 0, "rd_10_again");
        check_counts("after_hits", 32'd6, 32'd2);

        // Clean victim (way1), then dirty victim (way0) with writeback.
        push_fill(32'h210);
        cpu_access(1'b0, 32'h210, 32'h0, 32'h2A0, 6, "rd_210");
        push_back_word(32'h10, 32'hA0);
        push_back_word(32'h14, 32'hDEAD);
        push_back_word(32'h18, 32'hA2);
        push_back_word(32'h1C, 32'hA3);
        push_fill(32'h310);
        cpu_access(1'b0, 32'h310, 32'h0, 32'h3A0, 11, "rd_310");
        check_counts("after_rd_310", 32'd8, 32'd4);

        // Stretched acks: refill of the written-back line returns the stored data.
        ack_delay = 3;
        push_fill(32'h10);
        cpu_access(1'b0, 32'h18, 32'h0, 32'hA2, 18, "rd_18_slow");
        ack_delay = 0;
        cpu_access(1'b0, 32'h14, 32'h0, 32'hDEAD, 0, "rd_14_again");
        check_counts("after_slow", 32'd10, 32'd5);

        // Write miss allocates; data_r is untouched by writes.
        push_fill(32'h20);
        cpu_access(1'b1, 32'h24, 32'h1234, 32'h0, 6, "wr_24");
        check("wr_keeps_data_r", data_r, 32'hDEAD);
        cpu_access(1'b0, 32'h24, 32'h0, 32'h1234, 0, "rd_24");
        cpu_access(1'b0, 32'h20, 32'h0, 32'hA0, 0, "rd_20");
        check_counts("after_wr_miss", 32'd13, 32'd6);

        // Reset during the second FILL word.
        push_fill(32'h410);
        addr_rw = 32'h410;
        en_r = 1'b1;
        en_w = 1'b0;
        n = 0;
        @(negedge clk);
        while (mem_addr_o !== 32'h414 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("fill_second_word_reached", mem_addr_o, 32'h414);
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("mid_fill_reset");
        exp_mem_q.delete();
        en_r = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        push_fill(32'h410);
        cpu_access(1'b0, 32'h410, 32'h0, 32'h4A0, 6, "rd_410_after_reset");
        check_counts("after_reset", 32'd1, 32'd1);

        repeat (3) @(posedge clk);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
        check("mem_queue_drained", 32'(exp_mem_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
